// File: rtl/order_tx_scheduler.sv
// order_tx_scheduler: buffers buy/sell quote pairs in a FIFO and transmits each pair as two messages (buy, then sell) with an enforced idle gap
// Ports: i_clk/i_reset (async, active-high); i_valid + i_buy_msg/i_sell_msg push a pair;
//        o_msg/o_msg_valid/o_msg_side/i_msg_ready form the transmit handshake;
//        o_count/o_full report occupancy; o_drop_count saturates at 0xFFFF.
// Optional feature: define ORDER_TX_COALESCE_EN to overwrite the newest entry when full instead of dropping.
module order_tx_scheduler #(
  parameter int REG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic [9*REG_WIDTH-1:0]      i_buy_msg,
  input  logic [9*REG_WIDTH-1:0]      i_sell_msg,
  input  logic                        i_msg_ready,
  output logic [9*REG_WIDTH-1:0]      o_msg,
  output logic                        o_msg_valid,
  output logic                        o_msg_side,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_full,
  output logic [15:0]                 o_drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(MIN_GAP + 2);
  localparam int MW = 9 * REG_WIDTH;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [GW-1:0] GAP_LOAD = MIN_GAP[GW-1:0];
`ifdef ORDER_TX_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SEND_BUY, SEND_SELL, GAP} state_t;
  state_t state, state_n;
  logic [MW-1:0] buy_mem [FIFO_DEPTH];
  logic [MW-1:0] sell_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [GW-1:0] gap_cnt;
  logic full, pop, push, overwrite, drop;
  assign full = count == FULL_CNT;
  assign pop = state == SEND_SELL && i_msg_ready;
  // fullness is judged before any same-cycle pop, except that coalescing turns a full+pop cycle into a normal push
  assign push = i_valid && (!full || (COALESCE && pop));
  assign overwrite = COALESCE && i_valid && full && !pop;
  assign drop = i_valid && full && !push;
  assign o_msg_valid = state == SEND_BUY || state == SEND_SELL;
  assign o_msg_side = state == SEND_SELL;
  assign o_msg = o_msg_side ? sell_mem[rd_ptr] : buy_mem[rd_ptr];
  assign o_count = count;
  assign o_full = full;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = count != '0 ? SEND_BUY : IDLE;
      SEND_BUY:  state_n = i_msg_ready ? SEND_SELL : SEND_BUY;
      SEND_SELL: state_n = !i_msg_ready ? SEND_SELL : (MIN_GAP > 0 ? GAP : IDLE);
      GAP:       state_n = gap_cnt != '0 ? GAP : (count != '0 ? SEND_BUY : IDLE);
      default:   state_n = IDLE;
    endcase
  end
  // the counter is loaded while the sell is on the wire and runs down to zero inside GAP,
  // so the next buy can appear no earlier than MIN_GAP+1 edges after the sell handshake
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      gap_cnt <= '0;
      o_drop_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buy_mem[i] <= '0;
        sell_mem[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (push) begin
        buy_mem[wr_ptr] <= i_buy_msg;
        sell_mem[wr_ptr] <= i_sell_msg;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (overwrite) begin
        buy_mem[wr_ptr - 1'b1] <= i_buy_msg;
        sell_mem[wr_ptr - 1'b1] <= i_sell_msg;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      gap_cnt <= state == SEND_SELL ? GAP_LOAD : (gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt);
      if (drop && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_order_tx_scheduler.sv
// tb_order_tx_scheduler: table vectors, directed corner sequences and random traffic against a queue-based reference model
module tb_order_tx_scheduler;
  localparam int W = 32;
  localparam int D = 4;
  localparam int G = 16;
  localparam int MW = 9 * W;
`ifdef ORDER_TX_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif
  logic clk = 0, rst = 1, valid = 0, ready = 0;
  logic [MW-1:0] buy = '0, sell = '0, msg;
  logic msg_valid, side, full;
  logic [2:0] count;
  logic [15:0] drop;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  order_tx_scheduler #(.REG_WIDTH(W), .FIFO_DEPTH(D), .MIN_GAP(G)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_buy_msg(buy), .i_sell_msg(sell),
    .i_msg_ready(ready), .o_msg(msg), .o_msg_valid(msg_valid), .o_msg_side(side),
    .o_count(count), .o_full(full), .o_drop_count(drop));
  typedef struct {logic [MW-1:0] b; logic [MW-1:0] s;} pair_t;
  pair_t q[$];
  bit m_valid, m_side;
  int m_drops, cyc = 0, last_sell;
  typedef struct {bit v; logic [31:0] b0; logic [31:0] s0; bit r; bit ev; bit es; logic [31:0] ew; int ec;} vec_t;
  vec_t tbl[6];
  task automatic chk(string name, logic [MW-1:0] act, logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [MW-1:0] rnd();
    logic [MW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction
  task automatic model_reset();
    q.delete();
    m_valid = 0;
    m_side = 0;
    m_drops = 0;
    last_sell = -1000;
  endtask
  // one rising edge of the reference: pairs leave in order, a buy may start only once the
  // queue was non-empty before the edge and MIN_GAP+1 edges have passed since the last sell
  task automatic model_edge();
    bit ne, fl, pop;
    pair_t p;
    ne = q.size() > 0;
    fl = q.size() == D;
    pop = m_valid && m_side && ready;
    cyc++;
    p.b = buy;
    p.s = sell;
    if (pop) void'(q.pop_front());
    if (valid) begin
      if (!fl || (COAL && pop)) q.push_back(p);
      else begin
        if (COAL) q[q.size()-1] = p;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (m_valid && ready) begin
      if (m_side) begin
        m_valid = 0;
        last_sell = cyc;
      end
      m_side = !m_side;
    end else if (!m_valid && ne && cyc >= last_sell + G + 1) begin
      m_valid = 1;
      m_side = 0;
    end
  endtask
  task automatic check_model();
    chk("valid", msg_valid, m_valid);
    chk("side", side, m_valid && m_side);
    chk("count", count, q.size());
    chk("full", full, q.size() == D);
    chk("drops", drop, m_drops);
    if (m_valid && q.size() > 0) chk("msg", msg, m_side ? q[0].s : q[0].b);
  endtask
  task automatic step(bit v, logic [MW-1:0] b, logic [MW-1:0] s, bit r);
    valid = v;
    buy = b;
    sell = s;
    ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask
  task automatic idle(bit r, int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, r);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int t_sell, t_buy, got, drops0;
    logic [MW-1:0] m0, p;
    logic [31:0] order[4], want[4];
    tbl[0] = '{1, 32'h11, 32'h22, 1, 0, 0, 32'h0, 1};
    tbl[1] = '{0, 32'h0, 32'h0, 1, 1, 0, 32'h11, 1};
    tbl[2] = '{0, 32'h0, 32'h0, 1, 1, 1, 32'h22, 1};
    tbl[3] = '{0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0};
    tbl[4] = '{0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0};
    tbl[5] = '{0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0};
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", msg_valid, 0);
    chk("rst_side", side, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_drop", drop, 0);
    chk("rst_msg", msg, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, MW'(tbl[i].b0), MW'(tbl[i].s0), tbl[i].r);
      chk("tbl_valid", msg_valid, tbl[i].ev);
      chk("tbl_side", side, tbl[i].es);
      chk("tbl_count", count, tbl[i].ec);
      if (tbl[i].ev) chk("tbl_word0", msg[31:0], tbl[i].ew);
    end
    for (int i = 0; i < G; i++) begin
      step(0, '0, '0, 1);
      chk("gap_idle", msg_valid, 0);
    end
    idle(1, 4);
    // back-to-back pairs: second buy exactly MIN_GAP+1 edges after the first sell handshake
    step(1, rnd(), rnd(), 1);
    step(1, rnd(), rnd(), 1);
    t_sell = -1;
    t_buy = -1;
    for (int i = 0; i < 80 && t_buy < 0; i++) begin
      if (msg_valid && side && t_sell < 0) t_sell = cyc + 1;
      else if (msg_valid && !side && t_sell >= 0) t_buy = cyc;
      if (t_buy < 0) step(0, '0, '0, 1);
    end
    chk("b2b_gap", t_buy - t_sell, G + 1);
    idle(1, 40);
    // ready held low while the buy is presented
    step(1, rnd(), rnd(), 0);
    step(0, '0, '0, 0);
    chk("hold_valid", msg_valid, 1);
    m0 = msg;
    for (int i = 0; i < 10; i++) begin
      step(0, '0, '0, 0);
      chk("hold_msg", msg, m0);
      chk("hold_side", side, 0);
    end
    idle(1, 40);
    // six strobes into a depth-4 FIFO with ready low
    for (int k = 1; k <= 6; k++) step(1, MW'(k), MW'(k + 100), 0);
    chk("six_full", full, 1);
    chk("six_drop", drop, 2);
    want[0] = 1;
    want[1] = 2;
    want[2] = 3;
    want[3] = COAL ? 6 : 4;
    got = 0;
    for (int i = 0; i < 200 && got < 4; i++) begin
      if (msg_valid && !side) begin
        order[got] = msg[31:0];
        got++;
      end
      step(0, '0, '0, 1);
    end
    chk("six_sent", got, 4);
    for (int k = 0; k < 4; k++) chk("six_order", order[k], want[k]);
    idle(1, 40);
    // push coincident with the sell handshake while full
    for (int k = 0; k < 4; k++) step(1, rnd(), rnd(), 0);
    step(0, '0, '0, 1);
    chk("coin_side", side, 1);
    drops0 = int'(drop);
    step(1, rnd(), rnd(), 1);
    chk("coin_count", count, D - (COAL ? 0 : 1));
    chk("coin_drop", drop, drops0 + (COAL ? 0 : 1));
    idle(1, 120);
    // asynchronous reset during SEND_SELL
    step(1, rnd(), rnd(), 1);
    for (int i = 0; i < 40 && !(msg_valid && side); i++) step(0, '0, '0, 1);
    chk("pre_rst_sell", msg_valid && side, 1);
    ready = 0;
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_valid", msg_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_drop", drop, 0);
    @(negedge clk);
    rst = 0;
    p = rnd();
    step(1, p, rnd(), 1);
    chk("post_rst_lat1", msg_valid, 0);
    step(0, '0, '0, 1);
    chk("post_rst_lat2", msg_valid, 1);
    chk("post_rst_msg", msg, p);
    // randomized traffic against the reference model
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) == 0, rnd(), rnd(), $urandom_range(0, 2) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
